imem_loader: RTL
================

# imem_loader

Writes a program image into instruction memory from a byte stream and holds the core until the image is complete. It is the write side of instruction memory: it sits between a byte source (UART receiver or testbench driver) and the instruction memory write port. It assembles little-endian 32-bit instruction words, writes them at consecutive word-aligned addresses, and verifies an XOR checksum. The CPU is released only after a clean load.

## Interface

Parameters:
- MEM_WORDS, 256, number of 32-bit words in instruction memory; maximum legal image length.
- BASE_ADDR, 0, byte address of the first written word; must be a multiple of 4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session; ignored unless in IDLE.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle. A byte transfers when rx_valid && rx_ready.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  `DataBusBits  byte address of the word being written; bits [1:0] are always 0.
- imem_wdata  output  `InstrBusBits  instruction word being written.
- cpu_hold  output  1  high keeps the core stalled or in reset.
- busy  output  1  a session is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a session ends successfully.
- err  output  1  sticky error flag; cleared by reset or by an accepted start.

## Operation

Stream format, all fields little-endian:
- LEN: 2 bytes, the word count N.
- Payload: N×4 bytes; each group of 4 bytes forms one word, with the first byte in bits [7:0].
- CSUM: 1 byte, the XOR of all payload bytes.

State machine:
- IDLE: rx_ready=0. An accepted start clears err, the word counter, the byte index and the checksum accumulator, then moves to LEN0.
- LEN0: rx_ready=1. The accepted byte becomes len[7:0]. Next state is LEN1.
- LEN1: rx_ready=1. The accepted byte becomes len[15:8].
  - If the resulting len is 0 or greater than MEM_WORDS, set err and return to IDLE. No writes occur.
  - Otherwise go to DATA.
- DATA: rx_ready=1.
  - Each accepted byte is shifted into the word register at byte index 0..3 and XORed into the checksum.
  - When byte index 3 is accepted, the registered write fires on the next cycle: imem_we=1, imem_addr = BASE_ADDR + 4×word_cnt, imem_wdata = the assembled word. word_cnt then increments.
  - After word N−1 is accepted, go to CSUM.
- CSUM: rx_ready=1. The accepted byte is compared with the accumulator.
  - On a match, go to FINISH.
  - On a mismatch, set err and go to IDLE. Words already written are not undone.
- FINISH: pulse done for one cycle, drop cpu_hold, return to IDLE.

cpu_hold rules:
- Set by reset and by an accepted start.
- Cleared only in FINISH.
- An error session leaves it at 1.

Arithmetic:
- word_cnt is 9 bits wide, enough to hold 256.
- The address is computed at `DataBusBits width and zero-extended. It never wraps because len is capped at MEM_WORDS.

## Timing

Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0, state=IDLE.

Latency and cycle rules:
- start to rx_ready=1: 1 cycle.
- The 4th byte of a word is accepted in cycle t. imem_we=1 in cycle t+1, with imem_addr and imem_wdata stable for that cycle only.
- rx_ready stays 1 throughout LEN0, LEN1, DATA and CSUM. Back-to-back bytes are accepted every cycle with no stall.
- The write of the last word, in cycle t+1, coincides with the CSUM state. A CSUM byte may be accepted in that same cycle.
- After the CSUM byte is accepted in cycle c: done=1 and cpu_hold falls in cycle c+1, and busy=0 from cycle c+2.
- rx_valid=0 stalls the session indefinitely. There is no timeout.
- A start pulse while busy=1 is ignored and does not disturb the session.
- A simultaneous reset and start: reset wins.
- Reset mid-session aborts immediately to reset values. A pending write is dropped.

## Test plan

- Reset, start, then stream LEN=0x0002, bytes 13 00 50 00 93 00 10 00, CSUM=0xC0. Required: writes {addr 0x0, data 0x00500013} and {addr 0x4, data 0x00100093}, done pulses once, cpu_hold=0, err=0.
- Same stream with CSUM=0x00. Required: both words are written, err=1, no done pulse, cpu_hold=1.
- LEN=0x0101 (257). Required: err=1 after the LEN1 byte, zero imem_we pulses, return to IDLE.
- LEN=0x0100 with 1024 bytes at full rate and a correct CSUM. Required: 256 writes, last imem_addr=0x3FC, done pulses.
- Random rx_valid gaps plus a start pulse mid-payload. Required: word contents and addresses identical to the gap-free run, and the extra start has no effect.
- Assert reset after the 2nd payload word. Required: next-cycle outputs equal the reset values, and a following fresh session loads correctly from address 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed, XOR-checked program image
// into instruction memory and holds the core until the load is clean.
`ifndef DataBusBits
`define DataBusBits 32
`endif
`ifndef InstrBusBits
`define InstrBusBits 32
`endif

module imem_loader #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     imem_we,
    output logic [`DataBusBits-1:0]  imem_addr,
    output logic [`InstrBusBits-1:0] imem_wdata,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int AW = `DataBusBits;

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, CSUM, FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q;
    logic [8:0]  word_cnt_q;
    logic [1:0]  byte_idx_q;
    logic [7:0]  csum_q;
    logic [31:0] word_q;

    logic        xfer;
    logic        accept_start;
    logic [15:0] len_full;
    logic        len_bad;
    logic        last_word;
    logic        csum_ok;

    assign xfer      = rx_valid && rx_ready;
    assign len_full  = {rx_data, len_q[7:0]};
    assign len_bad   = (len_full == 16'd0) || (32'(len_full) > MEM_WORDS);
    assign last_word = ({7'd0, word_cnt_q} == (len_q - 16'd1));
    assign csum_ok   = (rx_data == csum_q);
    assign busy      = (state_q != IDLE);

    // State register; reset also overrides a coincident start.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode plus the per-state handshake and done pulse.
    always_comb begin
        state_d      = state_q;
        rx_ready     = 1'b0;
        done         = 1'b0;
        accept_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = LEN0;
                end
            end
            LEN0: begin
                rx_ready = 1'b1;
                if (rx_valid) state_d = LEN1;
            end
            LEN1: begin
                rx_ready = 1'b1;
                if (rx_valid) state_d = len_bad ? IDLE : DATA;
            end
            DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && byte_idx_q == 2'd3 && last_word)
                    state_d = CSUM;
            end
            CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) state_d = csum_ok ? FINISH : IDLE;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, checksum and the write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            word_q     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept_start) begin
                err        <= 1'b0;
                cpu_hold   <= 1'b1;
                word_cnt_q <= '0;
                byte_idx_q <= '0;
                csum_q     <= '0;
            end
            if (xfer) begin
                unique case (state_q)
                    LEN0: len_q[7:0] <= rx_data;
                    LEN1: begin
                        len_q[15:8] <= rx_data;
                        if (len_bad) err <= 1'b1;
                    end
                    DATA: begin
                        word_q     <= {rx_data, word_q[31:8]};
                        csum_q     <= csum_q ^ rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= AW'(BASE_ADDR)
                                        + AW'({word_cnt_q, 2'b00});
                            imem_wdata <= {rx_data, word_q[31:8]};
                            word_cnt_q <= word_cnt_q + 9'd1;
                        end
                    end
                    CSUM: begin
                        if (csum_ok) cpu_hold <= 1'b0;
                        else         err      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
